// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: constants shared by the data-memory arbiter and its
// round-robin picker.
//   M0 / M1        master indices into two-bit request and grant vectors
//   owner_t        lock-owner encoding (none / master 0 / master 1)
//   BURST_MAX_DEF  default cap on consecutive locked beats
package dmem_arb_pkg;

  localparam int M0 = 0;
  localparam int M1 = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick with a forced-owner override.
// Ports:
//   req[1:0]   request per master (index M0/M1)
//   last       master that won the most recent contention
//   force_en   a lock owner still holds priority this cycle
//   force_sel  which master owns the lock (0 = M0, 1 = M1)
//   gnt[1:0]   one-hot grant, all zero when nobody requests
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       force_en,
  input  logic       force_sel,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt[M0] = 1'b1;
      2'b10:   gnt[M1] = 1'b1;
      2'b11: begin
        // Under contention the lock owner wins while its burst lasts;
        // otherwise the master that did not win last time goes next.
        if (force_en) begin
          gnt[M1] = force_sel;
          gnt[M0] = ~force_sel;
        end else begin
          gnt[M1] = ~last;
          gnt[M0] = last;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core
// load/store unit (master 0) and a DMA/debug requester (master 1).
// At most one access is granted per cycle (grant is combinational);
// read data returns registered one cycle after the grant.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   mN_req/we/lock/addr/wdata        master N request fields
//   mN_gnt                           combinational grant to master N
//   mN_rvalid, mN_rdata              registered read return to master N
//   mem_we, mem_a, mem_wd, mem_rd    memory port (mem_rd is asynchronous)
// Build option: define DMEM_ARB_FIXED_PRIO_EN for fixed priority
// (master 0 always wins, lock ignored, no round-robin/lock state).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  // Reset suppresses every request, so no grant and no memory write.
  logic [1:0] req;
  logic [1:0] gnt;
  assign req = {m1_req, m0_req} & {2{~reset}};

`ifdef DMEM_ARB_FIXED_PRIO_EN

  logic lock_unused;
  assign lock_unused = m0_lock ^ m1_lock;
  assign gnt = {req[M1] & ~req[M0], req[M0]};

`else

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  logic       last;
  owner_t     owner;
  owner_t     owner_nxt;
  logic [3:0] beat_cnt;
  logic [3:0] cnt_nxt;
  logic       owner_req;
  logic       force_en;
  logic       force_sel;
  logic       gnt_sel;
  logic       gnt_lock;

  always_comb begin
    force_sel = (owner == OWN_M1);
    owner_req = force_sel ? req[M1] : req[M0];
    force_en  = (owner != OWN_NONE) && owner_req && (beat_cnt < BURST_LIM);
  end

  rr_arb2 u_rr (
    .req       (req),
    .last      (last),
    .force_en  (force_en),
    .force_sel (force_sel),
    .gnt       (gnt)
  );

  // Ownership survives only a granted beat with lock held; any other
  // outcome (unlock, no request, lost arbitration) releases it.
  always_comb begin
    owner_nxt = OWN_NONE;
    cnt_nxt   = 4'd0;
    gnt_sel   = gnt[M1];
    gnt_lock  = gnt_sel ? m1_lock : m0_lock;
    if ((|gnt) && gnt_lock) begin
      owner_nxt = gnt_sel ? OWN_M1 : OWN_M0;
      if (owner == owner_nxt) begin
        // Saturate so an uncontended long burst cannot wrap back
        // under the limit.
        cnt_nxt = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
      end else begin
        cnt_nxt = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      owner    <= OWN_NONE;
      beat_cnt <= 4'd0;
    end else begin
      if (&req) last <= gnt[M1];
      owner    <= owner_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

`endif

  assign m0_gnt = gnt[M0];
  assign m1_gnt = gnt[M1];
  assign mem_a  = gnt[M1] ? m1_addr  : m0_addr;
  assign mem_wd = gnt[M1] ? m1_wdata : m0_wdata;
  assign mem_we = (gnt[M0] & m0_we) | (gnt[M1] & m1_we);

  // Stage p0 -> p1: capture read data for the granted reader.
  logic [1:0]  rvld_p1;
  logic [31:0] rdata0_p1;
  logic [31:0] rdata1_p1;
  logic [1:0]  rd_p0;

  assign rd_p0 = {gnt[M1] & ~m1_we, gnt[M0] & ~m0_we};

  always_ff @(posedge clk) begin
    if (reset) begin
      rvld_p1   <= 2'b00;
      rdata0_p1 <= 32'd0;
      rdata1_p1 <= 32'd0;
    end else begin
      rvld_p1 <= rd_p0;
      if (rd_p0[M0]) rdata0_p1 <= mem_rd;
      if (rd_p0[M1]) rdata1_p1 <= mem_rd;
    end
  end

  assign m0_rvalid = rvld_p1[M0];
  assign m1_rvalid = rvld_p1[M1];
  assign m0_rdata  = rdata0_p1;
  assign m1_rdata  = rdata1_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter. A small memory
// array sits on the memory port; a behavioural model (grant rule, lock
// run length, shadow memory) predicts every output each cycle, followed
// by directed scenarios and a randomized phase.
module tb_dmem_arbiter;

  localparam int BMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.BURST_MAX(BMAX)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory attached to the DUT port (64 words, asynchronous read).
  logic [31:0] dmem [64];
  assign mem_rd = dmem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) dmem[mem_a[7:2]] <= mem_wd;

  int errors, checks;

  // Behavioural model state.
  logic [31:0] ref_mem [64];
  int          mdl_last, mdl_owner, mdl_run;
  logic        mdl_rv [2];
  logic [31:0] mdl_rd [2];
  int          exp_g;
  logic        exp_both, exp_we;
  logic [31:0] exp_a, exp_wd;
  logic        lock_g;
  logic        seen0, seen1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_last  = 1;
    mdl_owner = -1;
    mdl_run   = 0;
    mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
    mdl_rd[0] = 32'd0; mdl_rd[1] = 32'd0;
  endtask

  // Settle, predict this cycle's outputs and compare.
  task automatic eval();
    logic [1:0] r;
    #3;
    r = reset ? 2'b00 : {m1_req, m0_req};
    exp_both = (r == 2'b11);
    if (r == 2'b01) exp_g = 0;
    else if (r == 2'b10) exp_g = 1;
    else if (r == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      if (mdl_owner >= 0 && mdl_run < BMAX) exp_g = mdl_owner;
      else exp_g = 1 - mdl_last;
`endif
    end else exp_g = -1;
    exp_we = (exp_g == 0 && m0_we) || (exp_g == 1 && m1_we);
    exp_a  = (exp_g == 1) ? m1_addr : m0_addr;
    exp_wd = (exp_g == 1) ? m1_wdata : m0_wdata;
    lock_g = (exp_g == 1) ? m1_lock : m0_lock;
    chk("m0_gnt", 32'(m0_gnt), 32'(exp_g == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(exp_g == 1));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("mem_a", mem_a, exp_a);
    chk("mem_wd", mem_wd, exp_wd);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(mdl_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(mdl_rv[1]));
    chk("m0_rdata", m0_rdata, mdl_rd[0]);
    chk("m1_rdata", m1_rdata, mdl_rd[1]);
    seen0 = m0_gnt;
    seen1 = m1_gnt;
  endtask

  // Apply the predicted transfer to the model, then cross the clock edge.
  task automatic adv();
    if (reset) begin
      mdl_reset();
    end else begin
      mdl_rv[0] = 1'b0; mdl_rv[1] = 1'b0;
      if (exp_g >= 0) begin
        if (exp_both) mdl_last = exp_g;
`ifndef DMEM_ARB_FIXED_PRIO_EN
        if (lock_g) begin
          mdl_run   = (mdl_owner == exp_g) ? mdl_run + 1 : 1;
          mdl_owner = exp_g;
        end else begin
          mdl_owner = -1; mdl_run = 0;
        end
`endif
        if (exp_we) ref_mem[exp_a[7:2]] = exp_wd;
        else begin
          mdl_rv[exp_g] = 1'b1;
          mdl_rd[exp_g] = ref_mem[exp_a[7:2]];
        end
      end else begin
        mdl_owner = -1; mdl_run = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int m);
    logic        rq, w, lk;
    logic [31:0] a, d;
    rq = ($urandom_range(0, 3) != 0);
    w  = 1'($urandom_range(0, 1));
    lk = (m == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
    a  = 32'($urandom_range(0, 63)) << 2;
    d  = $urandom;
    if (m == 0) begin m0_req = rq; m0_we = w; m0_lock = lk; m0_addr = a; m0_wdata = d; end
    else        begin m1_req = rq; m1_we = w; m1_lock = lk; m1_addr = a; m1_wdata = d; end
  endtask

  initial begin
    errors = 0; checks = 0;
    for (int i = 0; i < 64; i++) begin dmem[i] = 32'd0; ref_mem[i] = 32'd0; end
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = 0; m1_wdata = 0;
    seen0 = 0; seen1 = 0;
    @(posedge clk); #1;
    mdl_reset();

    // Reset held with a write request pending: nothing may happen.
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
    eval();
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    adv();

    reset = 0;
    eval();
    chk("wr_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_a", mem_a, 32'h10);
    adv();
    m0_we = 0;
    eval();
    chk("rd_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("rd_mem_we", 32'(mem_we), 32'd0);
    adv();
    m0_req = 0;
    eval();
    chk("rd_m0_rvalid", 32'(m0_rvalid), 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    adv();

`ifndef DMEM_ARB_FIXED_PRIO_EN
    // Alternating contention, no lock.
    m0_req = 1; m0_we = 0; m0_lock = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_lock = 0; m1_addr = 32'h20;
    for (int i = 0; i < 6; i++) begin
      eval();
      chk("alt_m0_gnt", 32'(m0_gnt), 32'(i % 2 == 0));
      chk("alt_m1_gnt", 32'(m1_gnt), 32'(i % 2 == 1));
      if (i > 0) begin
        chk("alt_m0_rvalid", 32'(m0_rvalid), 32'((i - 1) % 2 == 0));
        chk("alt_m1_rvalid", 32'(m1_rvalid), 32'((i - 1) % 2 == 1));
      end
      adv();
    end
    m0_req = 0; m1_req = 0;
    eval();
    chk("alt_m1_rvalid_tail", 32'(m1_rvalid), 32'd1);
    chk("alt_m0_rdata", m0_rdata, 32'hDEADBEEF);
    adv();

    // M0 wins one unlocked contention, then M1 locks for a capped burst.
    m0_req = 1; m1_req = 1; m1_lock = 0;
    eval();
    chk("pre_m0_gnt", 32'(m0_gnt), 32'd1);
    adv();
    m1_lock = 1;
    for (int i = 0; i < 5; i++) begin
      eval();
      chk("burst_m1_gnt", 32'(m1_gnt), 32'(i < 4));
      chk("burst_m0_gnt", 32'(m0_gnt), 32'(i == 4));
      adv();
    end

    // Reset in the middle of a new M1 burst.
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("burst2_m1_gnt", 32'(m1_gnt), 32'd1);
      adv();
    end
    reset = 1;
    eval();
    chk("rstb_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rstb_m1_gnt", 32'(m1_gnt), 32'd0);
    adv();
    eval();
    chk("rstb2_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rstb2_m1_rvalid", 32'(m1_rvalid), 32'd0);
    chk("rstb2_m0_rvalid", 32'(m0_rvalid), 32'd0);
    adv();
    reset = 0;
    eval();
    chk("post_rst_m0_gnt", 32'(m0_gnt), 32'd1);
    chk("post_rst_m1_gnt", 32'(m1_gnt), 32'd0);
    adv();
`else
    // Fixed priority: M0 always wins, M1 lock has no effect.
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      eval();
      chk("fix_m0_gnt", 32'(m0_gnt), 32'd1);
      chk("fix_m1_gnt", 32'(m1_gnt), 32'd0);
      adv();
    end
`endif

    // Randomized traffic: masters hold each request until granted.
    m0_req = 0; m1_req = 0; seen0 = 0; seen1 = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!m0_req || seen0) new_req(0);
      if (!m1_req || seen1) new_req(1);
      eval();
      adv();
    end

    reset = 0; m0_req = 0; m1_req = 0;
    eval();
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter placed in front of the single-port data memory (`dmem`), sharing it between the core load/store unit (master 0) and a secondary requester (master 1: DMA or debug port). Each cycle it grants at most one request and steers that master's address, write data and write enable to the memory. It registers read data back to the winning master one cycle later. Arbitration is round-robin with an optional bounded lock for short bursts.

## Interface
Parameters:
- `BURST_MAX`, 4: maximum consecutive granted beats a locking master may hold before it must yield (range 1–15).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `m0_req`, `m1_req`  in  1  access request; must be held with its fields stable until granted.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read.
- `m0_lock`, `m1_lock`  in  1  request to keep ownership on the next cycle.
- `m0_addr`, `m1_addr`  in  32  byte address, forwarded unmodified.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_gnt`, `m1_gnt`  out  1  combinational grant; a transfer occurs when `req & gnt`.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse: read data is valid.
- `m0_rdata`, `m1_rdata`  out  32  registered read data, held until that master's next read completes.
- `mem_we`  out  1  to memory write enable.
- `mem_a`  out  32  to memory address.
- `mem_wd`  out  32  to memory write data.
- `mem_rd`  in  32  from memory asynchronous read data.

## Operation
- State registers:
  - `last` (1 bit): master granted most recently under contention.
  - `owner` (2 bits: none/M0/M1).
  - `beat_cnt` (4 bits).
  - `rvalid` flops and `rdata` registers for each master.
- Grant selection, evaluated each cycle:
  - `reset` high: no grant.
  - Only one master requesting: that master is granted.
  - Both requesting, and `owner` is set, still requests, and `beat_cnt < BURST_MAX`: the owner is granted.
  - Both requesting otherwise: the master ≠ `last` is granted.
- Memory steering:
  - `mem_a` and `mem_wd` come from the granted master. With no grant they come from master 0.
  - `mem_we` = granted master's `we` & grant. It is never 1 without a grant.
- On a granted read: `rdata` of that master ← `mem_rd` at the clock edge, and `rvalid` = 1 on the following cycle only.
- On a granted write: no `rvalid`, and `rdata` is unchanged.
- Under contention, `last` ← the granted master. `last` is unchanged when only one master requests.
- Lock and burst counter:
  - Granted with lock=1: `owner` ← that master; `beat_cnt` ← `beat_cnt`+1 if it was already the owner, else 1.
  - When `beat_cnt` reaches `BURST_MAX`, the owner loses priority, so the other master wins the next contention.
  - `owner` ← none and `beat_cnt` ← 0 when the owner is granted with lock=0, drops `req`, or loses arbitration.
- Reset state:
  - `last`=1, so master 0 wins the first contention.
  - `owner`=none, `beat_cnt`=0.
  - `m0_rvalid`/`m1_rvalid`=0, `m0_rdata`/`m1_rdata`=0.
  - Outputs during reset: all `gnt`=0, `mem_we`=0.
- Reset mid-burst clears ownership immediately. A read granted in the cycle `reset` rises produces no `rvalid`.

## Timing
- Grant latency is 0 cycles: `gnt` is combinational from `req`/`lock` and the state registers.
- A write commits at the rising edge that ends its grant cycle.
- Read data latency is 1 cycle: `rvalid` and `rdata` appear the cycle after the grant.
- Throughput is one access per cycle. Back-to-back reads by the same or alternating masters are legal.
- Simultaneous requests on the same cycle resolve by `last` or by lock; the loser sees `gnt`=0 and must hold its request.
- `m0_lock`/`m1_lock` is sampled only on cycles where that master is granted.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined:
  - Master 0 wins every contention.
  - Lock inputs are ignored.
  - `last`, `owner` and `beat_cnt` are not built.
- Not defined: round-robin arbitration with bounded lock, as described above.

## Structure
- Shared header/package `dmem_arb_pkg` holds:
  - master index constants `M0`=0, `M1`=1;
  - owner encoding constants;
  - `BURST_MAX` default.
- One sub-module, `rr_arb2`: two-way round-robin pick. Inputs: `req[1:0]`, `last`, and forced-owner. Output: one-hot `gnt[1:0]`. It is bypassed by a fixed-priority pick when the macro is defined.

## Test plan
- Reset, then M0 writes 0xDEADBEEF to 0x10 alone -> `m0_gnt`=1 that cycle and `mem_we`=1. M0 then reads 0x10 -> next cycle `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF.
- Both masters request reads every cycle for 6 cycles, no lock -> grants alternate M0, M1, M0, … starting with M0; each `rvalid` lands one cycle after its grant.
- M1 holds `lock`=1 with `BURST_MAX`=4 while M0 requests continuously -> M1 gets 4 consecutive grants, then M0 is granted on the 5th cycle.
- Assert `reset` during an M1 locked burst -> the following cycle both `gnt`=0, no `rvalid`, and the first contention after release grants M0.
- Build with `DMEM_ARB_FIXED_PRIO_EN`, both masters requesting with M1 `lock`=1 for 5 cycles -> `m0_gnt`=1 every cycle and `m1_gnt` never asserted.
